// File: rtl/state_pkg.sv
// state_pkg: animation codes consumed by the player sprite renderer
package state_pkg;
  typedef enum logic [2:0] {IDLE, RIGHT1, LEFT1, RIGHT2, LEFT2} State;
endpackage

// File: rtl/vga_pkg.sv
// vga_pkg: display geometry shared by the sprite controllers
package vga_pkg;
  localparam int H_RES    = 1024;
  localparam int V_RES    = 768;
  localparam int PLAYER_W = 40;
  localparam int PLAYER_H = 80;
endpackage

// File: rtl/frame_tick.sv
// frame_tick: one-cycle pulse on each vsync rising edge, no spurious pulse after reset
module frame_tick (
  input  logic clk,
  input  logic rst,
  input  logic vsync_i,
  output logic tick_o
);
  logic vsync_q;
  // previous vsync, reset high so a vsync already high at release is not an edge
  always_ff @(posedge clk)
    vsync_q <= rst ? 1'b1 : vsync_i;
  assign tick_o = vsync_i & ~vsync_q;
endmodule

// File: rtl/player1_ctl.sv
// player1_ctl: per-frame player-1 motion, jump and walk-animation controller
module player1_ctl
  import state_pkg::*;
  import vga_pkg::*;
#(
  parameter int X_MIN       = 0,
  parameter int X_MAX       = H_RES - PLAYER_W,
  parameter int X_START     = 100,
  parameter int Y_REST      = 100,
  parameter int STEP        = 4,
  parameter int JUMP_V0     = 12,
  parameter int GRAVITY     = 1,
  parameter int ANIM_FRAMES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        move_left,
  input  logic        move_right,
  input  logic        jump,
  output logic [11:0] xpos_player1,
  output logic [11:0] ypos_player1,
  output State        state
);
  typedef enum logic {GROUND, AIR} jmp_e;
  logic              tick, mv_r, mv_l, same_dir;
  logic        [11:0] x_q, x_d, y_q, y_d;
  logic        [12:0] x_up;
  logic signed [12:0] x_dn, y_n;
  logic signed [7:0]  vel_q, vel_d;
  logic        [7:0]  cnt_q, cnt_d;
  logic               phase_q, phase_d, armed_q, armed_d;
  jmp_e               jst_q, jst_d;
  State               st_q, st_d;
  frame_tick u_tick (.clk(clk), .rst(rst), .vsync_i(vsync), .tick_o(tick));
  // state register; a tick on the reset edge is discarded
  always_ff @(posedge clk)
    if (rst) begin
      x_q     <= 12'(X_START);
      y_q     <= 12'(Y_REST);
      vel_q   <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      armed_q <= 1'b1;
      jst_q   <= GROUND;
      st_q    <= IDLE;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      vel_q   <= vel_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      armed_q <= armed_d;
      jst_q   <= jst_d;
      st_q    <= st_d;
    end
  // next state: everything advances only on the frame tick
  always_comb begin
    mv_r     = move_right & ~move_left;
    mv_l     = move_left & ~move_right;
    x_up     = {1'b0, x_q} + 13'(STEP);
    x_dn     = $signed({1'b0, x_q}) - $signed(13'(STEP));
    y_n      = $signed({1'b0, y_q}) - $signed({{5{vel_q[7]}}, vel_q});
    same_dir = (mv_r && (st_q == RIGHT1 || st_q == RIGHT2)) || (mv_l && (st_q == LEFT1 || st_q == LEFT2));
    x_d      = x_q;
    y_d      = y_q;
    vel_d    = vel_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    armed_d  = armed_q;
    jst_d    = jst_q;
    st_d     = st_q;
    if (tick) begin
      x_d = mv_r ? (x_up > 13'(X_MAX) ? 12'(X_MAX) : x_up[11:0])
          : mv_l ? (x_dn < $signed(13'(X_MIN)) ? 12'(X_MIN) : x_dn[11:0])
          : x_q;
      armed_d = jump ? armed_q : 1'b1;
      if (jst_q == GROUND) begin
        if (jump && armed_q) begin
          jst_d   = AIR;
          vel_d   = 8'(JUMP_V0);
          armed_d = 1'b0;
        end
      end else if (y_n >= $signed(13'(Y_REST))) begin
        jst_d = GROUND;
        y_d   = 12'(Y_REST);
        vel_d = '0;
      end else begin
        y_d   = y_n[11:0];
        vel_d = vel_q - 8'(GRAVITY);
      end
      cnt_d   = (mv_r | mv_l) && same_dir && cnt_q != 8'(ANIM_FRAMES - 1) ? cnt_q + 8'd1 : '0;
      phase_d = (mv_r | mv_l) && same_dir && (cnt_q == 8'(ANIM_FRAMES - 1) ? ~phase_q : phase_q);
      st_d    = mv_r ? (phase_d ? RIGHT2 : RIGHT1) : mv_l ? (phase_d ? LEFT2 : LEFT1) : IDLE;
    end
  end
  // outputs come straight from the frame-stable registers
  always_comb begin
    xpos_player1 = x_q;
    ypos_player1 = y_q;
    state        = st_q;
  end
endmodule

// File: tb/tb_player1_ctl.sv
// tb_player1_ctl: directed self-checking bench for player1_ctl
module tb_player1_ctl;
  import state_pkg::*;
  logic        clk = 1'b0;
  logic        rst, vsync, move_left, move_right, jump;
  logic [11:0] xpos, ypos;
  State        st;
  int          compared = 0;
  int          mismatched = 0;
  int          jy[25] = '{88, 77, 67, 58, 50, 43, 37, 32, 28, 25, 23, 22, 22,
                          23, 25, 28, 32, 37, 43, 50, 58, 67, 77, 88, 100};
  player1_ctl dut (
    .clk(clk), .rst(rst), .vsync(vsync), .move_left(move_left),
    .move_right(move_right), .jump(jump), .xpos_player1(xpos),
    .ypos_player1(ypos), .state(st)
  );
  always #5 clk = ~clk;
  task automatic frame();
    @(negedge clk) vsync = 1'b1;
    @(negedge clk);
    @(negedge clk) vsync = 1'b0;
    repeat (3) @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1; vsync = 1'b0; move_left = 1'b0; move_right = 1'b0; jump = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_reset();
    do_reset();
    compared++;
    if (xpos !== 12'd100 || ypos !== 12'd100 || st !== IDLE) begin
      mismatched++;
      $display("FAIL reset: x=%0d y=%0d st=%0d, want 100 100 IDLE", xpos, ypos, st);
    end
    for (int i = 1; i <= 3; i++) begin
      frame();
      compared++;
      if (xpos !== 12'd100 || ypos !== 12'd100 || st !== IDLE) begin
        mismatched++;
        $display("FAIL idle_tick%0d: x=%0d y=%0d st=%0d, want 100 100 IDLE", i, xpos, ypos, st);
      end
    end
  endtask
  task automatic test_right();
    State exp;
    do_reset();
    move_right = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      frame();
      exp = (i >= 9 && i <= 16) ? RIGHT2 : RIGHT1;
      compared++;
      if (xpos !== 12'(100 + 4 * i) || st !== exp) begin
        mismatched++;
        $display("FAIL right_tick%0d: x=%0d st=%0d, want %0d %0d", i, xpos, st, 100 + 4 * i, exp);
      end
    end
    for (int i = 21; i <= 225; i++) frame();
    compared++;
    if (xpos !== 12'd984) begin
      mismatched++;
      $display("FAIL right_clamp: x=%0d, want 984", xpos);
    end
    move_right = 1'b0;
  endtask
  task automatic test_left();
    int ex[5] = '{4, 0, 0, 0, 0};
    do_reset();
    move_left = 1'b1;
    for (int i = 0; i < 23; i++) frame();
    move_left = 1'b0;
    frame();
    compared++;
    if (xpos !== 12'd8 || st !== IDLE) begin
      mismatched++;
      $display("FAIL left_setup: x=%0d st=%0d, want 8 IDLE", xpos, st);
    end
    move_left = 1'b1;
    for (int i = 0; i < 5; i++) begin
      frame();
      compared++;
      if (xpos !== 12'(ex[i]) || st !== LEFT1) begin
        mismatched++;
        $display("FAIL left_tick%0d: x=%0d st=%0d, want %0d LEFT1", i + 1, xpos, st, ex[i]);
      end
    end
    move_right = 1'b1;
    move_left = 1'b0;
    frame();
    move_left = 1'b1;
    for (int i = 0; i < 2; i++) begin
      frame();
      compared++;
      if (xpos !== 12'd4 || st !== IDLE) begin
        mismatched++;
        $display("FAIL both_dirs%0d: x=%0d st=%0d, want 4 IDLE", i, xpos, st);
      end
    end
    move_left = 1'b0; move_right = 1'b0;
  endtask
  task automatic test_jump();
    do_reset();
    jump = 1'b1;
    frame();
    jump = 1'b0;
    compared++;
    if (ypos !== 12'd100) begin
      mismatched++;
      $display("FAIL jump_take: y=%0d, want 100", ypos);
    end
    for (int i = 0; i < 25; i++) begin
      jump = (i == 4);
      frame();
      compared++;
      if (ypos !== 12'(jy[i]) || xpos !== 12'd100) begin
        mismatched++;
        $display("FAIL jump_tick%0d: y=%0d x=%0d, want %0d 100", i + 1, ypos, xpos, jy[i]);
      end
    end
    jump = 1'b0;
    for (int i = 0; i < 2; i++) begin
      frame();
      compared++;
      if (ypos !== 12'd100) begin
        mismatched++;
        $display("FAIL jump_landed%0d: y=%0d, want 100", i, ypos);
      end
    end
  endtask
  task automatic test_jump_hold();
    int ey;
    do_reset();
    jump = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      frame();
      ey = (i >= 2 && i <= 26) ? jy[i - 2] : 100;
      if (i % 4 == 0 || i == 2 || i == 13 || i == 27) begin
        compared++;
        if (ypos !== 12'(ey)) begin
          mismatched++;
          $display("FAIL hold_tick%0d: y=%0d, want %0d", i, ypos, ey);
        end
      end
    end
    jump = 1'b0;
    frame();
    jump = 1'b1;
    frame();
    frame();
    compared++;
    if (ypos !== 12'd88) begin
      mismatched++;
      $display("FAIL rejump: y=%0d, want 88", ypos);
    end
    jump = 1'b0;
  endtask
  task automatic test_reset_mid();
    do_reset();
    move_right = 1'b1;
    jump = 1'b1;
    frame();
    jump = 1'b0;
    for (int i = 0; i < 4; i++) frame();
    compared++;
    if (xpos !== 12'd120 || ypos !== 12'd58 || st !== RIGHT1) begin
      mismatched++;
      $display("FAIL pre_rst: x=%0d y=%0d st=%0d, want 120 58 RIGHT1", xpos, ypos, st);
    end
    @(negedge clk) begin rst = 1'b1; vsync = 1'b1; end
    @(negedge clk);
    compared++;
    if (xpos !== 12'd100 || ypos !== 12'd100 || st !== IDLE) begin
      mismatched++;
      $display("FAIL mid_rst: x=%0d y=%0d st=%0d, want 100 100 IDLE", xpos, ypos, st);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    compared++;
    if (xpos !== 12'd100 || ypos !== 12'd100 || st !== IDLE) begin
      mismatched++;
      $display("FAIL rst_release_high: x=%0d y=%0d st=%0d, want 100 100 IDLE", xpos, ypos, st);
    end
    vsync = 1'b0;
    repeat (2) @(negedge clk);
    frame();
    compared++;
    if (xpos !== 12'd104 || ypos !== 12'd100 || st !== RIGHT1) begin
      mismatched++;
      $display("FAIL post_rst_tick: x=%0d y=%0d st=%0d, want 104 100 RIGHT1", xpos, ypos, st);
    end
    move_right = 1'b0;
  endtask
  initial begin
    test_reset();
    test_right();
    test_left();
    test_jump();
    test_jump_hold();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
